// File: rtl/tcm_lsu_pkg.sv
// Shared types for the TCM load/store unit.
//   size_e   : access size encoding carried on the request (3 is illegal)
//   state_e  : request/response sequencing FSM states
//   req_t    : request attributes held from the accept cycle until the response
package tcm_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RSP  = 2'd2
  } state_e;

  // size is kept as raw bits so the illegal encoding can be stored and reported.
  typedef struct packed {
    logic [1:0] addr_lo;
    logic [1:0] size;
    logic       uns;
    logic       write;
    logic       err;
    logic [4:0] rd;
  } req_t;

endpackage

// File: rtl/tcm_lsu_if.sv
// Bundle of the LSU's request, response and TCM data-port signals.
//   slave  : the LSU side (takes requests, returns responses, drives the TCM)
//   master : the environment side (core pipeline + TCM macro)
interface tcm_lsu_if #(
  parameter int MEM_ADDR_WIDTH = 8
) ();
  logic                      i_req_valid;
  logic                      o_req_ready;
  logic [31:0]               i_req_addr;
  logic                      i_req_write;
  logic [1:0]                i_req_size;
  logic                      i_req_unsigned;
  logic [31:0]               i_req_wdata;
  logic [4:0]                i_req_rd;
  logic                      o_rsp_valid;
  logic                      i_rsp_ready;
  logic [31:0]               o_rsp_data;
  logic [4:0]                o_rsp_rd;
  logic                      o_rsp_err;
  logic                      o_tcm_sel;
  logic [MEM_ADDR_WIDTH-1:0] o_tcm_addr;
  logic                      o_tcm_write;
  logic [3:0]                o_tcm_mask;
  logic [31:0]               o_tcm_wdata;
  logic [31:0]               i_tcm_rdata;

  modport slave (
    input  i_req_valid, i_req_addr, i_req_write, i_req_size, i_req_unsigned,
           i_req_wdata, i_req_rd, i_rsp_ready, i_tcm_rdata,
    output o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_rd, o_rsp_err,
           o_tcm_sel, o_tcm_addr, o_tcm_write, o_tcm_mask, o_tcm_wdata
  );

  modport master (
    output i_req_valid, i_req_addr, i_req_write, i_req_size, i_req_unsigned,
           i_req_wdata, i_req_rd, i_rsp_ready, i_tcm_rdata,
    input  o_req_ready, o_rsp_valid, o_rsp_data, o_rsp_rd, o_rsp_err,
           o_tcm_sel, o_tcm_addr, o_tcm_write, o_tcm_mask, o_tcm_wdata
  );
endinterface

// File: rtl/tcm_lsu_fmt.sv
// Combinational data formatting for the LSU.
//   st_size/st_addr_lo/st_data -> st_mask/st_wdata : store lane replication + byte mask
//   ld_size/ld_addr_lo/ld_uns/ld_rdata -> ld_data  : load lane extraction + extension
module tcm_lsu_fmt
  import tcm_lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_data,
  output logic [3:0]  st_mask,
  output logic [31:0] st_wdata,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_uns,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] lane;

  // Store: replicate the right-justified data onto every lane, mask the addressed ones.
  always_comb begin
    st_mask  = 4'b0000;
    st_wdata = st_data;
    case (st_size)
      SZ_BYTE: begin
        st_wdata = {4{st_data[7:0]}};
        st_mask  = 4'b0001 << st_addr_lo;
      end
      SZ_HALF: begin
        st_wdata = {2{st_data[15:0]}};
        st_mask  = st_addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: begin
        st_wdata = st_data;
        st_mask  = 4'b1111;
      end
      default: begin
        st_wdata = st_data;
        st_mask  = 4'b0000;
      end
    endcase
  end

  // Load: shift the addressed lane down to bit 0, then sign- or zero-extend.
  always_comb begin
    lane    = ld_rdata >> {ld_addr_lo, 3'b000};
    ld_data = 32'h0000_0000;
    case (ld_size)
      SZ_BYTE: ld_data = {{24{~ld_uns & lane[7]}}, lane[7:0]};
      SZ_HALF: ld_data = {{16{~ld_uns & lane[15]}}, lane[15:0]};
      SZ_WORD: ld_data = ld_rdata;
      default: ld_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/tcm_lsu.sv
// Load/store initiator for the TCM data port.
//   i_clk, i_reset_n : clock and asynchronous active-low reset
//   bus (slave)      : request channel in, response channel out, TCM data port out
// A request is accepted in IDLE (or in RSP together with a response consume). The
// TCM is driven combinationally in the accept cycle; the read data arrives one
// cycle later (WAIT) and is formatted and registered into the response (RSP).
module tcm_lsu
  import tcm_lsu_pkg::*;
#(
  parameter int          MEM_ADDR_WIDTH = 8,
  parameter logic [31:0] TCM_BASE       = 32'h0000_0000
) (
  input  logic     i_clk,
  input  logic     i_reset_n,
  tcm_lsu_if.slave bus
);

  // Byte size of the TCM window; 33 bits so the compare never wraps.
  localparam logic [32:0] WINDOW = 33'd4 << MEM_ADDR_WIDTH;

  state_e      state;
  req_t        req_q;
  req_t        req_new;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_err;
  logic        req_ready;
  logic        accept;
  logic        misalign;
  logic        out_of_window;
  logic        req_err;
  logic [31:0] offset;
  logic [31:0] ld_data;

  // Request ready: free in IDLE, or in RSP when the current response is being consumed.
  always_comb begin
    req_ready = 1'b0;
    case (state)
      ST_IDLE: req_ready = 1'b1;
      ST_WAIT: req_ready = 1'b0;
      ST_RSP:  req_ready = bus.i_rsp_ready;
      default: req_ready = 1'b0;
    endcase
  end

  // Request error classification: illegal size, misalignment, outside the window.
  always_comb begin
    misalign = 1'b0;
    case (bus.i_req_size)
      SZ_BYTE: misalign = 1'b0;
      SZ_HALF: misalign = bus.i_req_addr[0];
      SZ_WORD: misalign = (bus.i_req_addr[1:0] != 2'b00);
      default: misalign = 1'b1;
    endcase
    offset        = bus.i_req_addr - TCM_BASE;
    out_of_window = ({1'b0, offset} >= WINDOW);
    req_err       = misalign | out_of_window;
  end

  assign accept = bus.i_req_valid & req_ready;

  assign req_new = '{addr_lo: bus.i_req_addr[1:0],
                     size:    bus.i_req_size,
                     uns:     bus.i_req_unsigned,
                     write:   bus.i_req_write,
                     err:     req_err,
                     rd:      bus.i_req_rd};

  // Reset gating keeps the TCM untouched even if a request is presented during reset.
  assign bus.o_req_ready = req_ready;
  assign bus.o_tcm_sel   = accept & ~req_err & i_reset_n;
  assign bus.o_tcm_write = bus.o_tcm_sel & bus.i_req_write;
  assign bus.o_tcm_addr  = bus.i_req_addr[MEM_ADDR_WIDTH+1:2];

  tcm_lsu_fmt u_fmt (
    .st_size    (bus.i_req_size),
    .st_addr_lo (bus.i_req_addr[1:0]),
    .st_data    (bus.i_req_wdata),
    .st_mask    (bus.o_tcm_mask),
    .st_wdata   (bus.o_tcm_wdata),
    .ld_size    (req_q.size),
    .ld_addr_lo (req_q.addr_lo),
    .ld_uns     (req_q.uns),
    .ld_rdata   (bus.i_tcm_rdata),
    .ld_data    (ld_data)
  );

  // Sequencing FSM with registered response outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= ST_IDLE;
      req_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0000_0000;
      rsp_rd    <= 5'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            req_q <= req_new;
            state <= ST_WAIT;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          rsp_valid <= 1'b1;
          rsp_data  <= (req_q.err | req_q.write) ? 32'h0000_0000 : ld_data;
          rsp_rd    <= req_q.rd;
          rsp_err   <= req_q.err;
          state     <= ST_RSP;
        end
        ST_RSP: begin
          if (bus.i_rsp_ready) begin
            rsp_valid <= 1'b0;
            if (accept) begin
              req_q <= req_new;
              state <= ST_WAIT;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            state <= ST_RSP;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_data  = rsp_data;
  assign bus.o_rsp_rd    = rsp_rd;
  assign bus.o_rsp_err   = rsp_err;

endmodule

// File: tb/tb_tcm_lsu.sv
// Directed testbench for tcm_lsu with a behavioural registered-read TCM model.
module tb_tcm_lsu;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  tcm_lsu_if #(.MEM_ADDR_WIDTH(8)) bus ();

  tcm_lsu #(.MEM_ADDR_WIDTH(8), .TCM_BASE(32'h0000_0000)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // TCM model: masked write and registered read on sel, plus a bench preload port.
  logic [31:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;
  int          sel_count;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (bus.o_tcm_sel) begin
      sel_count <= sel_count + 1;
      bus.i_tcm_rdata <= mem[bus.o_tcm_addr];
      if (bus.o_tcm_write) begin
        for (int b = 0; b < 4; b++)
          if (bus.o_tcm_mask[b]) mem[bus.o_tcm_addr][8*b +: 8] <= bus.o_tcm_wdata[8*b +: 8];
      end
    end
  end

  // Values captured by do_req
  logic        a_sel, a_write;
  logic [7:0]  a_addr;
  logic [3:0]  a_mask;
  logic [31:0] a_wdata;
  int          r_lat;
  logic [31:0] r_data;
  logic [4:0]  r_rd;
  logic        r_err;

  task automatic preload(input logic [7:0] ad, input logic [31:0] d);
    @(posedge clk); #1;
    pl_en = 1'b1; pl_addr = ad; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // One request from IDLE, consumed as soon as it is valid; records accept-cycle TCM drive.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic un,
                        input logic [31:0] ad, input logic [31:0] wd, input logic [4:0] rd);
    int n;
    @(posedge clk); #1;
    bus.i_req_valid = 1'b1; bus.i_req_write = wr; bus.i_req_size = sz;
    bus.i_req_unsigned = un; bus.i_req_addr = ad; bus.i_req_wdata = wd;
    bus.i_req_rd = rd; bus.i_rsp_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.o_req_ready && n < 20) begin @(negedge clk); n++; end
    a_sel = bus.o_tcm_sel; a_write = bus.o_tcm_write; a_addr = bus.o_tcm_addr;
    a_mask = bus.o_tcm_mask; a_wdata = bus.o_tcm_wdata;
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
    r_lat = 1;
    @(negedge clk);
    while (!bus.o_rsp_valid && r_lat < 20) begin @(negedge clk); r_lat++; end
    r_data = bus.o_rsp_data; r_rd = bus.o_rsp_rd; r_err = bus.o_rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.o_req_ready !== 1'b1 || bus.o_rsp_valid !== 1'b0 || bus.o_tcm_sel !== 1'b0 ||
        bus.o_rsp_data !== 32'h0 || bus.o_rsp_rd !== 5'd0 || bus.o_rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got ready=%b valid=%b sel=%b data=%h rd=%0d err=%b exp ready=1 valid=0 sel=0 data=0 rd=0 err=0",
               bus.o_req_ready, bus.o_rsp_valid, bus.o_tcm_sel, bus.o_rsp_data, bus.o_rsp_rd, bus.o_rsp_err);
    end
  endtask

  task automatic test_load();
    do_req(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 5'd1);
    checks++;
    if (r_lat !== 2 || r_data !== 32'hFFFF_FF88 || r_rd !== 5'd1 || r_err !== 1'b0 ||
        a_sel !== 1'b1 || a_write !== 1'b0 || a_addr !== 8'h40) begin
      errors++;
      $display("FAIL lb got lat=%0d data=%h rd=%0d err=%b sel=%b wr=%b addr=%h exp lat=2 data=ffffff88 rd=1 err=0 sel=1 wr=0 addr=40",
               r_lat, r_data, r_rd, r_err, a_sel, a_write, a_addr);
    end
    do_req(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 5'd2);
    checks++;
    if (r_data !== 32'h0000_0088 || r_rd !== 5'd2) begin
      errors++; $display("FAIL lbu got data=%h rd=%0d exp data=00000088 rd=2", r_data, r_rd);
    end
    do_req(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 5'd3);
    checks++;
    if (r_data !== 32'hFFFF_8899) begin
      errors++; $display("FAIL lh got data=%h exp ffff8899", r_data);
    end
    do_req(1'b0, 2'd1, 1'b1, 32'h100, 32'h0, 5'd3);
    checks++;
    if (r_data !== 32'h0000_AABB) begin
      errors++; $display("FAIL lhu got data=%h exp 0000aabb", r_data);
    end
  endtask

  task automatic test_store();
    do_req(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000_1234, 5'd4);
    checks++;
    if (a_sel !== 1'b1 || a_write !== 1'b1 || a_addr !== 8'h40 || a_mask !== 4'b1100 ||
        a_wdata !== 32'h1234_1234) begin
      errors++;
      $display("FAIL sh_drive got sel=%b wr=%b addr=%h mask=%b wdata=%h exp 1 1 40 1100 12341234",
               a_sel, a_write, a_addr, a_mask, a_wdata);
    end
    checks++;
    if (r_lat !== 2 || r_data !== 32'h0 || r_err !== 1'b0 || r_rd !== 5'd4) begin
      errors++; $display("FAIL sh_rsp got lat=%0d data=%h err=%b rd=%0d exp 2 0 0 4", r_lat, r_data, r_err, r_rd);
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd5);
    checks++;
    if (r_data !== 32'h1234_AABB) begin
      errors++; $display("FAIL lw_after_sh got data=%h exp 1234aabb", r_data);
    end
    do_req(1'b1, 2'd0, 1'b0, 32'h101, 32'h0000_005A, 5'd6);
    checks++;
    if (a_mask !== 4'b0010 || a_wdata !== 32'h5A5A_5A5A || mem[8'h40] !== 32'h1234_5ABB) begin
      errors++; $display("FAIL sb got mask=%b wdata=%h mem=%h exp 0010 5a5a5a5a 12345abb", a_mask, a_wdata, mem[8'h40]);
    end
    do_req(1'b1, 2'd2, 1'b0, 32'h104, 32'hDEAD_BEEF, 5'd6);
    checks++;
    if (a_mask !== 4'b1111 || a_wdata !== 32'hDEAD_BEEF || a_addr !== 8'h41 || mem[8'h41] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL sw got mask=%b wdata=%h addr=%h mem=%h exp 1111 deadbeef 41 deadbeef", a_mask, a_wdata, a_addr, mem[8'h41]);
    end
  endtask

  task automatic test_errors();
    int s0;
    s0 = sel_count;
    do_req(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 5'd11);
    checks++;
    if (a_sel !== 1'b0 || r_err !== 1'b1 || r_data !== 32'h0 || r_rd !== 5'd11 || r_lat !== 2) begin
      errors++; $display("FAIL lw_misalign got sel=%b err=%b data=%h rd=%0d lat=%0d exp 0 1 0 11 2", a_sel, r_err, r_data, r_rd, r_lat);
    end
    do_req(1'b1, 2'd1, 1'b0, 32'h101, 32'hFFFF_FFFF, 5'd12);
    checks++;
    if (a_sel !== 1'b0 || r_err !== 1'b1 || r_data !== 32'h0 || r_rd !== 5'd12) begin
      errors++; $display("FAIL sh_misalign got sel=%b err=%b data=%h rd=%0d exp 0 1 0 12", a_sel, r_err, r_data, r_rd);
    end
    do_req(1'b0, 2'd3, 1'b0, 32'h100, 32'h0, 5'd13);
    checks++;
    if (a_sel !== 1'b0 || r_err !== 1'b1 || r_rd !== 5'd13) begin
      errors++; $display("FAIL size3 got sel=%b err=%b rd=%0d exp 0 1 13", a_sel, r_err, r_rd);
    end
    checks++;
    if (sel_count !== s0 || mem[8'h40] !== 32'h1234_5ABB) begin
      errors++; $display("FAIL err_no_access got sel_cycles=%0d mem=%h exp sel_cycles=%0d mem=12345abb", sel_count, mem[8'h40], s0);
    end
  endtask

  task automatic test_window();
    do_req(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 5'd14);
    checks++;
    if (a_sel !== 1'b0 || r_err !== 1'b1 || r_data !== 32'h0) begin
      errors++; $display("FAIL lw_0x400 got sel=%b err=%b data=%h exp 0 1 0", a_sel, r_err, r_data);
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 5'd15);
    checks++;
    if (a_sel !== 1'b1 || a_addr !== 8'hFF || r_err !== 1'b0 || r_data !== 32'hCAFE_F00D) begin
      errors++; $display("FAIL lw_0x3fc got sel=%b addr=%h err=%b data=%h exp 1 ff 0 cafef00d", a_sel, a_addr, r_err, r_data);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    @(posedge clk); #1;
    bus.i_req_valid = 1'b1; bus.i_req_write = 1'b0; bus.i_req_size = 2'd2;
    bus.i_req_unsigned = 1'b0; bus.i_req_addr = 32'h100; bus.i_req_rd = 5'd7;
    bus.i_rsp_ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    bus.i_req_size = 2'd0; bus.i_req_unsigned = 1'b1; bus.i_req_rd = 5'd9;
    n = 0;
    @(negedge clk);
    while (!bus.o_rsp_valid && n < 20) begin @(negedge clk); n++; end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_data !== 32'h1234_5ABB || bus.o_rsp_rd !== 5'd7 ||
          bus.o_req_ready !== 1'b0 || bus.o_tcm_sel !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got valid=%b data=%h rd=%0d ready=%b sel=%b exp 1 12345abb 7 0 0",
                 i, bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_rd, bus.o_req_ready, bus.o_tcm_sel);
      end
      if (i < 2) @(negedge clk);
    end
    @(posedge clk); #1;
    bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.o_req_ready !== 1'b1 || bus.o_rsp_valid !== 1'b1 || bus.o_tcm_sel !== 1'b1) begin
      errors++; $display("FAIL bp_release got ready=%b valid=%b sel=%b exp 1 1 1", bus.o_req_ready, bus.o_rsp_valid, bus.o_tcm_sel);
    end
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.o_rsp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_wait got valid=%b exp 0", bus.o_rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.o_rsp_valid !== 1'b1 || bus.o_rsp_data !== 32'h0000_00BB || bus.o_rsp_rd !== 5'd9) begin
      errors++; $display("FAIL b2b_rsp got valid=%b data=%h rd=%0d exp 1 000000bb 9", bus.o_rsp_valid, bus.o_rsp_data, bus.o_rsp_rd);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int s0;
    bus.i_req_valid = 1'b1; bus.i_req_write = 1'b0; bus.i_req_size = 2'd2;
    bus.i_req_addr = 32'h100; bus.i_req_rd = 5'd3; bus.i_rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
    @(negedge clk);
    // now in WAIT; o_rsp_data still holds the previous response
    rst_n = 1'b0;
    bus.i_req_valid = 1'b1;
    s0 = sel_count;
    #1;
    checks++;
    if (bus.o_rsp_valid !== 1'b0 || bus.o_rsp_data !== 32'h0 || bus.o_req_ready !== 1'b1 || bus.o_tcm_sel !== 1'b0) begin
      errors++; $display("FAIL rst_mid got valid=%b data=%h ready=%b sel=%b exp 0 0 1 0", bus.o_rsp_valid, bus.o_rsp_data, bus.o_req_ready, bus.o_tcm_sel);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.i_req_valid = 1'b0;
    rst_n = 1'b1;
    checks++;
    if (sel_count !== s0) begin
      errors++; $display("FAIL rst_no_access got sel_cycles=%0d exp %0d", sel_count, s0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (bus.o_rsp_valid !== 1'b0 || bus.o_req_ready !== 1'b1) begin
        errors++; $display("FAIL rst_after[%0d] got valid=%b ready=%b exp 0 1", i, bus.o_rsp_valid, bus.o_req_ready);
      end
    end
    do_req(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 5'd20);
    checks++;
    if (r_lat !== 2 || r_data !== 32'hDEAD_BEEF || r_rd !== 5'd20) begin
      errors++; $display("FAIL rst_then_lw got lat=%0d data=%h rd=%0d exp 2 deadbeef 20", r_lat, r_data, r_rd);
    end
  endtask

  initial begin
    checks = 0; errors = 0; sel_count = 0;
    rst_n = 1'b0;
    pl_en = 1'b0; pl_addr = 8'h0; pl_data = 32'h0;
    bus.i_req_valid = 1'b0; bus.i_req_addr = 32'h0; bus.i_req_write = 1'b0;
    bus.i_req_size = 2'd0; bus.i_req_unsigned = 1'b0; bus.i_req_wdata = 32'h0;
    bus.i_req_rd = 5'd0; bus.i_rsp_ready = 1'b1; bus.i_tcm_rdata = 32'h0;
    test_reset();
    preload(8'h40, 32'h8899_AABB);
    preload(8'hFF, 32'hCAFE_F00D);
    @(posedge clk); #1;
    rst_n = 1'b1;
    test_load();
    test_store();
    test_errors();
    test_window();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
